rca_slot_lsq: RTL and testbench
===============================

# rca_slot_lsq

Per-slot load/store queue for the reconfigurable compute array. Accepts memory requests from one grid PR slot over the slot's LSQ interface (`addr`/`data`/`fn3`/`load`/`store`/`new_request` in, `lsq_full`/`load_data`/`load_complete` out). Buffers them in order and issues them one at a time to a single-ported data-memory port. Returns sign/zero-extended load results to the slot.

## Interface
- `DEPTH`, default 4: request queue entries; must be a power of two, at least 2.
- `XLEN`, default 32: data/address width (from `taiga_config`).
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `addr`  in  XLEN  request byte address from slot.
- `data`  in  XLEN  store data from slot; least-significant bytes are used.
- `fn3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `load`, `store`  in  1  request type; exactly one of the two must be high with `new_request`.
- `new_request`  in  1  request valid; accepted when `lsq_full`=0.
- `lsq_full`  out  1  queue cannot accept this cycle.
- `load_data`  out  XLEN  extended load result.
- `load_complete`  out  1  one-cycle pulse; `load_data` is valid in that cycle.
- `mem_addr`  out  XLEN  word-aligned address (bits [1:0]=0).
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_re`, `mem_we`  out  1  read/write request; held until `mem_ack`.
- `mem_ack`  in  1  memory accepted the current request.
- `mem_rvalid`  in  1  read data return.
- `mem_rdata`  in  XLEN  raw read word.

## Operation
- Queue: circular FIFO of {addr, data, fn3, is_load}. Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. `count` = wr_ptr − rd_ptr.
- Push: `new_request && !lsq_full && (load ^ store)`. A request with `load == store` is discarded silently. A request while `lsq_full`=1 is ignored.
- `lsq_full` is registered and equals (count == DEPTH) after the update. A pop and a push in the same cycle when count == DEPTH is not possible, because the push is rejected.
- FSM states:
  - IDLE → ISSUE when the queue is non-empty.
  - ISSUE drives the head entry on the memory port.
    - On `mem_ack`, a store pops the head and goes to IDLE, or stays in ISSUE if another entry is queued.
    - On `mem_ack`, a load goes to WAIT_RD.
  - WAIT_RD: on `mem_rvalid`, pop the head, register the extended data, pulse `load_complete`, then go to IDLE.
- Ordering: strictly in-order. At most one memory transaction is outstanding.
- Store lanes, with off = addr[1:0]:
  - B: `mem_be` = 0001<<off; wdata = {4{data[7:0]}}.
  - H: `mem_be` = 0011<<off; wdata = {2{data[15:0]}}.
  - W: `mem_be` = 1111; wdata = data.
- Load extract: shift `mem_rdata` right by 8·off. Then sign-extend from bit 7/15 for B/H, or zero-extend for BU/HU. W passes through.
- Reset values:
  - `lsq_full`=0, `load_complete`=0, `load_data`=0.
  - `mem_re`=`mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
  - FSM=IDLE, pointers=0.
- Reset mid-transaction: all queued entries are dropped. A `mem_rvalid` arriving after reset while in IDLE is ignored.

## Timing
- An entry pushed in cycle N is registered at edge N. `mem_re`/`mem_we` assert in cycle N+1 at the earliest, because FSM leaves IDLE at edge N and drives in N+1.
- `mem_*` outputs come from the head entry and FSM state, and stay stable until `mem_ack`.
- Store throughput: one per cycle when `mem_ack` is held high. The ISSUE→ISSUE transition takes zero idle cycles.
- `load_complete`/`load_data` are registered: the pulse occurs the cycle after `mem_rvalid`.
- Each load takes a minimum of 3 cycles from push to `load_complete` (1 issue cycle + 1 rvalid cycle + 1 register cycle).
- `lsq_full` deasserts the cycle after the pop edge.

## Configuration
- `RCA_LSQ_MISALIGN_CHECK_EN` defined:
  - H/HU with addr[0]=1, or W with addr[1:0]≠0, is not issued to memory.
  - The entry is popped in one ISSUE cycle.
  - A misaligned load returns `load_data`=0 with a `load_complete` pulse.
  - Extra output `misalign_err` (1 bit) pulses for one cycle, aligned with the pop.
- Not defined:
  - No check and no `misalign_err` port.
  - Misaligned H/W requests use off masked to 2'b10 for H and 2'b00 for W, i.e. the natural-aligned container.

## Test plan
- Reset, then LW to 0x100 with `mem_rdata`=0xDEADBEEF and ack/rvalid given immediately → `load_complete` pulse 3 cycles after push, `load_data`=0xDEADBEEF.
- LB to 0x103 with rdata=0x80123456 → `load_data`=0xFFFFFF80. LBU to the same address → 0x00000080.
- SH to 0x202 with data 0x1234ABCD → `mem_addr`=0x200, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_we` held until ack.
- Push DEPTH stores with `mem_ack`=0 → `lsq_full`=1. An extra `new_request` is ignored (count stays DEPTH). Release ack → DEPTH writes occur in order, and `lsq_full` falls the cycle after the first pop.
- Load followed by store while `mem_rvalid` is delayed 5 cycles → store is not issued until the load completes.
- Assert `rst` during WAIT_RD, then apply a stray `mem_rvalid` → no `load_complete`, and all outputs are at reset values. With `RCA_LSQ_MISALIGN_CHECK_EN`: LW to 0x101 → no `mem_re`, `misalign_err` pulses, `load_data`=0.

Source files
------------

// File: rtl/rca_slot_lsq.sv
// Per-slot load/store queue: in-order request FIFO issuing to a single-ported data memory.
// Optional misalignment trap enabled by defining RCA_LSQ_MISALIGN_CHECK_EN (adds misalign_err).
module rca_slot_lsq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  output logic            mem_re,
  output logic            mem_we,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t          state_q, state_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q;
  logic [XLEN-1:0] q_addr [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [2:0]      q_fn3  [DEPTH];
  logic [DEPTH-1:0] q_load;
  logic            full_q;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic            ld_cmp_q, ld_cmp_d;
  logic            push, pop, more;
  logic [XLEN-1:0] h_addr, h_data, shifted, ext, wdata;
  logic [2:0]      h_fn3;
  logic            h_load;
  logic [1:0]      off;
  logic [3:0]      be;

  assign push    = new_request && !full_q && (load ^ store);
  assign count_q = wr_ptr_q - rd_ptr_q;
  // Another entry remains after popping the head (including one arriving now).
  assign more    = (count_q > (PW+1)'(1)) || push;

  assign h_addr = q_addr[rd_ptr_q[PW-1:0]];
  assign h_data = q_data[rd_ptr_q[PW-1:0]];
  assign h_fn3  = q_fn3[rd_ptr_q[PW-1:0]];
  assign h_load = q_load[rd_ptr_q[PW-1:0]];

  // Halfword/word offsets snap to the naturally aligned container.
  always_comb begin
    off   = h_addr[1:0];
    be    = 4'b1111;
    wdata = h_data;
    unique case (h_fn3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {(XLEN/8){h_data[7:0]}};
      end
      2'b01: begin
        off   = {h_addr[1], 1'b0};
        be    = 4'b0011 << off;
        wdata = {(XLEN/16){h_data[15:0]}};
      end
      default: off = 2'b00;
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};
    unique case (h_fn3[1:0])
      2'b00:   ext = {{(XLEN-8){~h_fn3[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   ext = {{(XLEN-16){~h_fn3[2] & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

`ifdef RCA_LSQ_MISALIGN_CHECK_EN
  logic mis;
  assign mis = ((h_fn3[1:0] == 2'b01) && h_addr[0]) ||
               (h_fn3[1] && (h_addr[1:0] != 2'b00));
`endif

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    ld_data_d = ld_data_q;
    ld_cmp_d  = 1'b0;
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
    misalign_err = 1'b0;
`endif
    unique case (state_q)
      IDLE: if ((count_q != '0) || push) state_d = ISSUE;
      ISSUE: begin
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
        if (mis) begin
          pop          = 1'b1;
          misalign_err = 1'b1;
          if (h_load) begin
            ld_data_d = '0;
            ld_cmp_d  = 1'b1;
          end
          state_d = more ? ISSUE : IDLE;
        end else begin
`endif
          mem_re    = h_load;
          mem_we    = !h_load;
          mem_addr  = {h_addr[XLEN-1:2], 2'b00};
          mem_wdata = wdata;
          mem_be    = be;
          if (mem_ack) begin
            if (h_load) begin
              state_d = WAIT_RD;
            end else begin
              pop     = 1'b1;
              state_d = more ? ISSUE : IDLE;
            end
          end
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
        end
`endif
      end
      WAIT_RD: if (mem_rvalid) begin
        pop       = 1'b1;
        ld_data_d = ext;
        ld_cmp_d  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      full_q    <= 1'b0;
      ld_data_q <= '0;
      ld_cmp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      full_q    <= (wr_ptr_d - rd_ptr_d) == (PW+1)'(DEPTH);
      ld_data_q <= ld_data_d;
      ld_cmp_q  <= ld_cmp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr_q[PW-1:0]] <= addr;
      q_data[wr_ptr_q[PW-1:0]] <= data;
      q_fn3[wr_ptr_q[PW-1:0]]  <= fn3;
      q_load[wr_ptr_q[PW-1:0]] <= load;
    end
  end

  assign lsq_full      = full_q;
  assign load_data     = ld_data_q;
  assign load_complete = ld_cmp_q;

endmodule

// File: tb/tb_rca_slot_lsq.sv
// Scoreboard bench for rca_slot_lsq: reference model predicts memory transactions and load results.
module tb_rca_slot_lsq;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, data = '0, mem_rdata = '0;
  logic [2:0]  fn3 = '0;
  logic        load = 1'b0, store = 1'b0, new_request = 1'b0;
  logic        mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic        lsq_full, load_complete, mem_re, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign_err;

  always #5 clk = ~clk;

  rca_slot_lsq #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3), .load(load), .store(store),
    .new_request(new_request), .lsq_full(lsq_full), .load_data(load_data),
    .load_complete(load_complete), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_re(mem_re), .mem_we(mem_we), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );
`ifndef RCA_LSQ_MISALIGN_CHECK_EN
  assign misalign_err = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_mem_q[$];
  logic [31:0] exp_ld_q[$];
  int          checks = 0, errors = 0, exp_mis = 0, seen_mis = 0;
  logic [31:0] special_word = 32'hDEADBEEF;

  // Memory knobs: ack_mode 0 = never, 1 = always, 2 = random.
  int ack_mode = 1, rv_delay = 0;
  bit rv_rand = 0, stray_rv = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return special_word;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: what the memory port and the slot should see for one accepted request.
  function automatic void model_push(input logic [31:0] a, input logic [31:0] d,
                                     input logic [2:0] f, input logic ld);
    int unsigned off, sz, eoff;
    txn_t        t;
    logic [31:0] v;
    bit          mis;
    off  = 32'(a[1:0]);
    sz   = 32'(f[1:0]);
    eoff = (sz == 0) ? off : (sz == 1) ? (off / 2) * 2 : 0;
    mis  = 1'b0;
`ifdef RCA_LSQ_MISALIGN_CHECK_EN
    mis = (sz == 1 && off % 2 == 1) || (sz >= 2 && off != 0);
`endif
    if (mis) begin
      exp_mis++;
      if (ld) exp_ld_q.push_back('0);
      return;
    end
    t.we    = !ld;
    t.addr  = a & ~32'h3;
    t.be    = (sz == 0) ? 4'(1 << eoff) : (sz == 1) ? 4'(3 << eoff) : 4'hF;
    t.wdata = (sz == 0) ? (d & 32'hFF) * 32'h01010101 :
              (sz == 1) ? (d & 32'hFFFF) * 32'h00010001 : d;
    exp_mem_q.push_back(t);
    if (ld) begin
      v = mem_word(t.addr) >> (8 * eoff);
      if (sz == 0) begin
        v = v & 32'hFF;
        if (!f[2] && v >= 128) v = v | 32'hFFFFFF00;
      end else if (sz == 1) begin
        v = v & 32'hFFFF;
        if (!f[2] && v >= 32768) v = v | 32'hFFFF0000;
      end
      exp_ld_q.push_back(v);
    end
  endfunction

  // Memory responder.
  bit          rd_out = 0;
  int          rd_cnt = 0;
  logic [31:0] rd_addr = '0;
  initial forever begin
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_ack    = 1'b0;
    if (rst) begin
      rd_out = 0;
    end else begin
      if (stray_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
      end else if (rd_out) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(rd_addr);
          rd_out     = 0;
        end else rd_cnt--;
      end
      if ((mem_re || mem_we) && (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 1) == 1)))
        mem_ack = 1'b1;
      if (mem_re && mem_ack) begin
        rd_out  = 1;
        rd_addr = mem_addr;
        rd_cnt  = rv_rand ? int'($urandom_range(0, 3)) : rv_delay;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake or a load result.
  bit          rd_pending = 0;
  txn_t        mt;
  logic [31:0] mld;
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      rd_pending = 0;
    end else begin
      if (misalign_err) seen_mis++;
      if (load_complete) begin
        rd_pending = 0;
        if (exp_ld_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL load_unexpected actual=%h required=none", load_data);
        end else begin
          mld = exp_ld_q.pop_front();
          check("load_data", load_data, mld);
        end
      end
      if ((mem_re || mem_we) && mem_ack) begin
        checks++;
        if (rd_pending) begin
          errors++;
          $display("FAIL one_outstanding actual=issued required=wait addr=%h", mem_addr);
        end
        if (exp_mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected actual addr=%h we=%b required=none", mem_addr, mem_we);
        end else begin
          mt = exp_mem_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(mt.we));
          check("mem_re", 32'(mem_re), 32'(!mt.we));
          check("mem_addr", mem_addr, mt.addr);
          if (mt.we) begin
            check("mem_be", 32'(mem_be), 32'(mt.be));
            check("mem_wdata", mem_wdata, mt.wdata);
          end
        end
        if (mem_re) rd_pending = 1;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic ld, input logic st);
    @(negedge clk);
    addr = a; data = d; fn3 = f; load = ld; store = st; new_request = 1'b1;
    if (!lsq_full && (ld ^ st)) model_push(a, d, f, ld);
  endtask

  task automatic quiet();
    @(negedge clk);
    new_request = 1'b0; load = 1'b0; store = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((exp_mem_q.size() != 0 || exp_ld_q.size() != 0) && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_mem_q.size() != 0 || exp_ld_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", exp_mem_q.size(), exp_ld_q.size());
      exp_mem_q.delete();
      exp_ld_q.delete();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_rst_outputs();
    check("rst_lsq_full", 32'(lsq_full), 0);
    check("rst_load_complete", 32'(load_complete), 0);
    check("rst_load_data", load_data, 0);
    check("rst_mem_re", 32'(mem_re), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
  endtask

  initial begin
    int lat;
    bit got, we_early, done;
    logic [2:0] ld_fn [5];
    ld_fn = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    repeat (3) @(negedge clk);
    #1;
    check_rst_outputs();
    @(negedge clk);
    rst = 1'b0;

    // LW latency and data.
    issue(32'h100, 32'h0, 3'b010, 1'b1, 1'b0);
    got = 0; lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      new_request = 1'b0; load = 1'b0;
      #1;
      if (load_complete && !got) begin
        got = 1; lat = i;
        check("lw_data", load_data, 32'hDEADBEEF);
      end
    end
    check("lw_latency", lat, 3);
    wait_idle(50);

    // Byte loads, signed and unsigned.
    special_word = 32'h80123456;
    issue(32'h103, 32'h0, 3'b000, 1'b1, 1'b0);
    issue(32'h103, 32'h0, 3'b100, 1'b1, 1'b0);
    quiet();
    wait_idle(50);

    // SH held without ack.
    ack_mode = 0;
    issue(32'h202, 32'h1234ABCD, 3'b001, 1'b0, 1'b1);
    quiet();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("sh_we_held", 32'(mem_we), 1);
      check("sh_addr", mem_addr, 32'h200);
      check("sh_be", 32'(mem_be), 32'hC);
      check("sh_wdata", mem_wdata, 32'hABCDABCD);
    end
    ack_mode = 1;
    wait_idle(50);

    // Fill the queue, extra request ignored, full drops one cycle after first pop.
    ack_mode = 0;
    for (int i = 0; i < DEPTH; i++) issue(32'h300 + 32'(4 * i), $urandom, 3'b010, 1'b0, 1'b1);
    issue(32'h3F0, 32'h55AA55AA, 3'b010, 1'b0, 1'b1);
    #1;
    check("full_set", 32'(lsq_full), 1);
    quiet();
    #1;
    check("full_after_extra", 32'(lsq_full), 1);
    ack_mode = 1;
    @(negedge clk);
    #1;
    check("full_before_pop", 32'(lsq_full), 1);
    @(negedge clk);
    #1;
    check("full_falls", 32'(lsq_full), 0);
    wait_idle(50);

    // Load then store with slow read data: store must wait.
    rv_delay = 5;
    issue(32'h140, 32'h0, 3'b010, 1'b1, 1'b0);
    issue(32'h144, 32'hCAFEF00D, 3'b010, 1'b0, 1'b1);
    quiet();
    we_early = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      if (load_complete) done = 1;
      else if (mem_we) we_early = 1;
    end
    check("store_waits", 32'(we_early), 0);
    check("load_done", 32'(done), 1);
    rv_delay = 0;
    wait_idle(50);

    // Reset during WAIT_RD, then a stray rvalid.
    rv_delay = 10;
    issue(32'h180, 32'h0, 3'b010, 1'b1, 1'b0);
    quiet();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    exp_mem_q.delete();
    exp_ld_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    stray_rv = 1;
    @(negedge clk);
    #2;
    stray_rv = 0;
    rv_delay = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("no_stray_complete", 32'(load_complete), 0);
    end
    check_rst_outputs();

    // Misaligned word load (trapped when the check is built in).
    issue(32'h101, 32'h0, 3'b010, 1'b1, 1'b0);
    quiet();
    wait_idle(50);

    // Randomized traffic with random ack and read latency.
    ack_mode = 2;
    rv_rand  = 1;
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic ld, st;
      r = $urandom_range(0, 15);
      if (r < 4) quiet();
      else begin
        ld = r[0];
        st = !r[0];
        if (r == 15) st = ld;
        issue(32'h400 + $urandom_range(0, 255), $urandom,
              ld ? ld_fn[$urandom_range(0, 4)] : 3'($urandom_range(0, 2)), ld, st);
      end
    end
    quiet();
    ack_mode = 1;
    wait_idle(2000);
    check("misalign_pulses", seen_mis, exp_mis);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
